// File: rtl/rtl_packetizer.sv
// Packs user words into 4-flit NoC packets: one head flit carrying the
// destination, then up to three data flits, with long messages split.
module rtl_packetizer #(
  parameter int WIDTH_NOC   = 9,
  parameter int N           = 16,
  parameter int NUM_VC      = 2,
  parameter int ASSIGNED_VC = 0,
  localparam int ADDRESS_WIDTH    = $clog2(N),
  localparam int VC_ADDRESS_WIDTH = $clog2(NUM_VC),
  localparam int WIDTH_DATA       = WIDTH_NOC - 3 - VC_ADDRESS_WIDTH,
  localparam int WIDTH_RTL        = 4 * WIDTH_NOC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH_DATA-1:0]    i_data_in,
  input  logic [ADDRESS_WIDTH-1:0] i_dest_in,
  input  logic                     i_last_in,
  input  logic                     i_valid_in,
  output logic                     i_ready_out,
  output logic [WIDTH_RTL-1:0]     o_packet_out,
  output logic                     o_valid_out,
  input  logic                     o_ready_in
);

  localparam logic [VC_ADDRESS_WIDTH-1:0] VC =
    VC_ADDRESS_WIDTH'(ASSIGNED_VC);
  localparam int W = WIDTH_NOC;

  typedef enum logic [1:0] {
    IDLE,
    FILL1,
    FILL2,
    CONT
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] dest_q;
  logic [WIDTH_DATA-1:0]    w0_q;
  logic [WIDTH_DATA-1:0]    w1_q;

  logic                     accept;
  logic                     closing;
  logic [ADDRESS_WIDTH-1:0] cur_dest;
  logic [WIDTH_RTL-1:0]     pkt_next;

  function automatic logic [W-1:0] flit(
    input logic                  head,
    input logic                  tail,
    input logic [WIDTH_DATA-1:0] d
  );
    return {1'b1, head, tail, VC, d};
  endfunction

  assign i_ready_out = !o_valid_out || o_ready_in;
  assign accept      = i_valid_in && i_ready_out;

  always_comb begin
    cur_dest = (state == IDLE) ? i_dest_in : dest_q;
    closing  = i_last_in || (state == FILL2);
    pkt_next = '0;
    pkt_next[W-1:0] = flit(1'b1, 1'b0, WIDTH_DATA'(cur_dest));
    // Held words never close a packet, so only the incoming word is tail.
    unique case (state)
      FILL1: begin
        pkt_next[2*W-1:W]   = flit(1'b0, 1'b0, w0_q);
        pkt_next[3*W-1:2*W] = flit(1'b0, 1'b1, i_data_in);
      end
      FILL2: begin
        pkt_next[2*W-1:W]   = flit(1'b0, 1'b0, w0_q);
        pkt_next[3*W-1:2*W] = flit(1'b0, 1'b0, w1_q);
        pkt_next[4*W-1:3*W] = flit(1'b0, 1'b1, i_data_in);
      end
      default: begin
        pkt_next[2*W-1:W]   = flit(1'b0, 1'b1, i_data_in);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dest_q       <= '0;
      w0_q         <= '0;
      w1_q         <= '0;
      o_valid_out  <= 1'b0;
      o_packet_out <= '0;
    end else begin
      if (o_ready_in) begin
        o_valid_out <= 1'b0;
      end
      if (accept) begin
        dest_q <= cur_dest;
        if (closing) begin
          o_packet_out <= pkt_next;
          o_valid_out  <= 1'b1;
          state        <= i_last_in ? IDLE : CONT;
        end else if (state == FILL1) begin
          w1_q  <= i_data_in;
          state <= FILL2;
        end else begin
          w0_q  <= i_data_in;
          state <= FILL1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtl_packetizer.sv
// Directed and randomized checks of rtl_packetizer against a
// message-level packet model.
module tb_rtl_packetizer;

  logic        clk;
  logic        rst;
  logic [4:0]  i_data_in;
  logic [3:0]  i_dest_in;
  logic        i_last_in;
  logic        i_valid_in;
  logic        i_ready_out;
  logic [35:0] o_packet_out;
  logic        o_valid_out;
  logic        o_ready_in;

  int checks = 0;
  int errors = 0;

  rtl_packetizer dut (
    .clk          (clk),
    .rst          (rst),
    .i_data_in    (i_data_in),
    .i_dest_in    (i_dest_in),
    .i_last_in    (i_last_in),
    .i_valid_in   (i_valid_in),
    .i_ready_out  (i_ready_out),
    .o_packet_out (o_packet_out),
    .o_valid_out  (o_valid_out),
    .o_ready_in   (o_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] mk_flit(input int head, input int tail,
                                          input int data);
    return 36'((1 << 8) + (head << 7) + (tail << 6) + (0 << 5) + data);
  endfunction

  // Expected packet for n (1..3) words a,b,c of a message to dest.
  function automatic logic [35:0] build(input int dest, input int n,
                                        input int a, input int b,
                                        input int c);
    logic [35:0] p;
    int w [3];
    w[0] = a; w[1] = b; w[2] = c;
    p = mk_flit(1, 0, dest);
    for (int k = 1; k <= n; k++)
      p = p | (mk_flit(0, (k == n) ? 1 : 0, w[k-1]) << (9 * k));
    return p;
  endfunction

  task automatic drive(input logic v, input logic [4:0] d,
                       input logic [3:0] dst, input logic l,
                       input logic r);
    @(negedge clk);
    i_valid_in = v;
    i_data_in  = d;
    i_dest_in  = dst;
    i_last_in  = l;
    o_ready_in = r;
    #1;
  endtask

  logic [4:0]  wd [$];
  logic [3:0]  wdst [$];
  logic        wl [$];
  logic [35:0] expq [$];

  initial begin
    int total, idx, cyc, len, dest, cnt;
    int bufw [3];
    logic hold;
    logic [35:0] held;
    logic v;

    rst = 1'b1;
    i_valid_in = 1'b0;
    i_data_in = '0;
    i_dest_in = '0;
    i_last_in = 1'b0;
    o_ready_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(o_valid_out), 64'd0);
    chk("rst_packet", 64'(o_packet_out), 64'd0);
    chk("rst_ready", 64'(i_ready_out), 64'd1);

    // single word message
    drive(1, 5'h1A, 4'd5, 1, 1);
    drive(0, 5'h00, 4'd0, 0, 1);
    chk("t1_valid", 64'(o_valid_out), 64'd1);
    chk("t1_flit0", 64'(o_packet_out[8:0]), 64'h185);
    chk("t1_flit1", 64'(o_packet_out[17:9]), 64'h15A);
    chk("t1_flit23", 64'(o_packet_out[35:18]), 64'd0);
    drive(0, 5'h00, 4'd0, 0, 1);
    chk("t1_drain", 64'(o_valid_out), 64'd0);

    // five-word message, split 3+2; dest changes on later words ignored
    drive(1, 5'h01, 4'd3, 0, 1);
    drive(1, 5'h02, 4'd9, 0, 1);
    drive(1, 5'h03, 4'd9, 0, 1);
    drive(1, 5'h04, 4'd9, 0, 1);
    chk("t2_a_valid", 64'(o_valid_out), 64'd1);
    chk("t2_a_pkt", 64'(o_packet_out), 64'(build(3, 3, 1, 2, 3)));
    chk("t2_a_tail3", 64'(o_packet_out[33]), 64'd1);
    drive(1, 5'h05, 4'd9, 1, 1);
    drive(0, 5'h00, 4'd0, 0, 1);
    chk("t2_b_pkt", 64'(o_packet_out), 64'(build(3, 2, 4, 5, 0)));
    chk("t2_b_flit3", 64'(o_packet_out[35:27]), 64'd0);

    // backpressure
    drive(1, 5'h11, 4'd2, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 5'h12, 4'd4, 1, 0);
      chk("t3_ready_low", 64'(i_ready_out), 64'd0);
      chk("t3_stable", 64'({o_valid_out, o_packet_out}),
          64'({1'b1, build(2, 1, 5'h11, 0, 0)}));
    end
    drive(1, 5'h12, 4'd4, 1, 1);
    chk("t3_ready_high", 64'(i_ready_out), 64'd1);
    drive(0, 5'h00, 4'd0, 0, 1);
    chk("t3_no_bubble", 64'({o_valid_out, o_packet_out}),
        64'({1'b1, build(4, 1, 5'h12, 0, 0)}));
    drive(0, 5'h00, 4'd0, 0, 1);
    chk("t3_drain", 64'(o_valid_out), 64'd0);

    // back-to-back single-word messages
    drive(1, 5'h07, 4'd1, 1, 1);
    drive(1, 5'h08, 4'd2, 1, 1);
    chk("t4_pkt1", 64'({o_valid_out, o_packet_out}),
        64'({1'b1, build(1, 1, 7, 0, 0)}));
    drive(1, 5'h09, 4'd3, 1, 1);
    chk("t4_pkt2", 64'({o_valid_out, o_packet_out}),
        64'({1'b1, build(2, 1, 8, 0, 0)}));
    drive(0, 5'h00, 4'd0, 0, 1);
    chk("t4_pkt3", 64'({o_valid_out, o_packet_out}),
        64'({1'b1, build(3, 1, 9, 0, 0)}));

    // reset mid-message with a pending packet
    drive(1, 5'h04, 4'd6, 0, 0);
    drive(1, 5'h05, 4'd6, 0, 0);
    drive(1, 5'h1F, 4'd8, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    i_valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_valid", 64'(o_valid_out), 64'd0);
    chk("t5_packet", 64'(o_packet_out), 64'd0);
    drive(1, 5'h0B, 4'd7, 1, 1);
    drive(0, 5'h00, 4'd0, 0, 1);
    chk("t5_pkt", 64'({o_valid_out, o_packet_out}),
        64'({1'b1, build(7, 1, 5'h0B, 0, 0)}));

    // random messages with random valid/ready
    while (wd.size() < 10000) begin
      len = $urandom_range(1, 8);
      dest = $urandom_range(0, 15);
      cnt = 0;
      for (int i = 0; i < len; i++) begin
        bufw[cnt] = $urandom_range(0, 31);
        wd.push_back(5'(bufw[cnt]));
        wdst.push_back((i == 0) ? 4'(dest) : 4'($urandom_range(0, 15)));
        wl.push_back(i == len - 1);
        cnt++;
        if (cnt == 3 || i == len - 1) begin
          expq.push_back(build(dest, cnt, bufw[0], bufw[1], bufw[2]));
          cnt = 0;
        end
      end
    end
    total = wd.size();
    idx = 0;
    cyc = 0;
    hold = 1'b0;
    held = '0;
    while ((idx < total || expq.size() > 0) && cyc < 80000) begin
      v = (idx < total) && ($urandom_range(0, 3) != 0);
      if (v)
        drive(1, wd[idx], wdst[idx], wl[idx], $urandom_range(0, 3) != 0);
      else
        drive(0, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      chk("rand_ready", 64'(i_ready_out), 64'(!o_valid_out || o_ready_in));
      if (hold)
        chk("rand_hold", 64'({o_valid_out, o_packet_out}),
            64'({1'b1, held}));
      if (o_valid_out && o_ready_in) begin
        if (expq.size() == 0)
          chk("rand_extra_pkt", 64'(o_packet_out), 64'd0);
        else
          chk("rand_pkt", 64'(o_packet_out), 64'(expq.pop_front()));
      end
      hold = o_valid_out && !o_ready_in;
      held = o_packet_out;
      if (i_valid_in && i_ready_out)
        idx++;
      cyc++;
    end
    chk("rand_complete", 64'((total - idx) + expq.size()), 64'd0);
    i_valid_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
